muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative M-extension multiply/divide sequencer that sits beside the EX-stage ALU.
- Accepts one operation from the ID/EX register after forwarding muxes and holds the pipeline with a stall while it works.
- Returns a registered 32-bit result with its destination register.
- Sequences a shared 32-step shift/add-subtract datapath; one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width.
- STEPS, 32, iterations per operation; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort (branch/jump flush).
- start  input  1  ID/EX holds an M-op (opcode 0110011, funct7 0000001).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value, already forwarded.
- op_b  input  XLEN  rs2 value, already forwarded.
- rd_in  input  5  destination register.
- stall_out  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  FSM in MUL, DIV or FIX.
- done  output  1  result valid, one cycle.
- result  output  XLEN  product/quotient/remainder.
- rd_out  output  5  destination register of the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0. busy, done, result, rd_out and all internal registers are 0. stall_out=0 while rst_n=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE with start=1 and flush=0: latch funct3, rd_in and operand magnitudes.
  - Record the sign flags: sign_a for MULH/MULHSU/DIV/REM; sign_b for MULH/DIV/REM.
  - If a special case applies, go straight to DONE. Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1) with cnt=0.
- Special cases (fast path):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=op_a.
  - Signed overflow, op_a=0x80000000 with op_b=0xFFFFFFFF under DIV/REM: quotient=0x80000000, remainder=0.
- MUL state: unsigned shift-add on magnitudes into a 64-bit accumulator, one bit per cycle, cnt++. At cnt=STEPS-1, next state is FIX.
- DIV state: restoring division on magnitudes, one quotient bit per cycle, cnt++. At cnt=STEPS-1, next state is FIX.
- FIX state (one cycle):
  - Products: negate the 64-bit product if sign_a XOR sign_b.
  - Quotient: negate if sign_a XOR sign_b.
  - Remainder: takes the sign of the dividend (negate if sign_a).
  - Select low 32 bits for MUL, high 32 bits for MULH*, quotient or remainder by funct3. Register into result, then go to DONE.
- DONE state (one cycle): done=1, result and rd_out valid. Next state is IDLE unconditionally. start is ignored here, because it is still the same instruction.
- stall_out = (state==IDLE & start & ~flush) | busy. It is deasserted in DONE so ID/EX advances at the end of that cycle.
- Latency, with start sampled in cycle C0:
  - Normal: MUL/DIV in C1..C32, FIX in C33, done=1 in C34.
  - Special case: done=1 in C1.
- Throughput: a new start can be accepted at the earliest in the IDLE cycle after DONE. start while busy is ignored; upstream is held by stall_out.
- flush=1 in any state: next state IDLE, cnt=0, no done pulse, start ignored that cycle. result holds its last value.
- rst_n low mid-operation: immediate return to reset values; no done.
- result and rd_out hold their values after DONE until the next FIX or fast-path load.
- All arithmetic is modulo 2^32 on outputs. Negation is two's complement; |0x80000000| = 0x80000000 treated as unsigned.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5, start in C0 -> stall_out=1 in C0..C33, done=1 in C34, result=0xFFFFFFEB, rd_out=5.
- MULH 0x80000000×0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done in C1, result=0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in C1. REM same -> 0.
- DIV started in C0, flush=1 in C10 -> IDLE in C11, stall_out=0, no done; a new MUL 3×4 started in C12 -> done in C46 with result=12.
- rst_n pulsed low in C20 of a MUL -> busy, stall_out, done and result are 0 immediately; start held high during DONE of a normal op does not retrigger.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit sharing one shift/add-subtract datapath.
// One op in flight; stalls the pipeline until the registered result is presented for one cycle.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            stall_out,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(STEPS);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_sa, r_sb;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              w_signed_a, w_signed_b, w_sa, w_sb, w_dz, w_ovf, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast, w_quo, w_rem, w_fix;
  logic [XLEN:0]     w_mul_sum, w_trial;
  logic [2*XLEN-1:0] w_mul_acc, w_div_acc, w_prod;
  assign w_signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_signed_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_sa       = w_signed_a & op_a[XLEN-1];
  assign w_sb       = w_signed_b & op_b[XLEN-1];
  assign w_mag_a    = w_sa ? -op_a : op_a;
  assign w_mag_b    = w_sb ? -op_b : op_b;
  assign w_dz       = funct3[2] & (op_b == '0);
  assign w_ovf      = funct3[2] & ~funct3[0] & (op_a == MIN) & (op_b == '1);
  assign w_special  = w_dz | w_ovf;
  assign w_fast     = w_dz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN);
  // Shift-add: multiplier sits in the low half and drains out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_acc  = {w_mul_sum, r_acc[XLEN-1:1]};
  // Restoring divide: high half is the partial remainder, low half fills with quotient bits.
  assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
  assign w_div_acc  = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0} : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_prod     = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo      = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem      = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix      = r_f3[2] ? (r_f3[1] ? w_rem : w_quo) : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  assign busy       = (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX);
  assign done       = (r_state == S_DONE) & ~flush;
  assign stall_out  = rst_n & (((r_state == S_IDLE) & start & ~flush) | busy);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = w_special ? S_DONE : (funct3[2] ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (r_cnt == CW'(STEPS-1)) w_next = S_FIX;
      S_FIX:        w_next = S_DONE;
      default:      w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      r_state <= w_next;
      if (flush) r_cnt <= '0;
      else case (r_state)
        S_IDLE: if (start) begin
          r_f3  <= funct3;
          r_rd  <= rd_in;
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_b   <= w_mag_b;
          r_acc <= {{XLEN{1'b0}}, w_mag_a};
          r_cnt <= '0;
          if (w_special) begin
            result <= w_fast;
            rd_out <= rd_in;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          result <= w_fix;
          rd_out <= r_rd;
        end
        default: ;
      endcase
    end
  end
endmodule
